// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and helpers for the four-way round-robin arbiter
//
// Contents:
//   NUM_REQ         number of requesters (fixed at 4)
//   IDX_W           width of an encoded requester index
//   ST_IDLE         FSM state: no grant active
//   ST_GRANT        FSM state: one owner holds the resource
//   idx_to_onehot   encoded index -> one-hot grant vector

package arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_pick_4.sv
// rtl/rr_pick_4.sv - combinational round-robin winner selection over four requests
//
// Ports:
//   req        in   4  request vector, bit i is requester i
//   ptr        in   2  highest-priority requester for this search
//   win_idx    out  2  index of the first set request in order ptr, ptr+1, ptr+2, ptr+3
//   win_valid  out  1  at least one request is set (win_idx meaningful)

module rr_pick_4
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   win_idx,
   output logic               win_valid
);

   logic [NUM_REQ-1:0] rot;
   logic [IDX_W-1:0]   off;

   // Rotate so that the ptr requester lands in bit 0; the 2-bit index sum
   // wraps mod 4 on its own.
   always_comb begin
      rot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rot[i] = req[IDX_W'(i) + ptr];
      end
   end

   // Fixed-priority encode, lowest rotated bit wins. Scanning downward lets
   // the last assignment (lowest set bit) take effect.
   always_comb begin
      off = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = IDX_W'(i);
         end
      end
   end

   assign win_idx   = off + ptr;
   assign win_valid = |req;

endmodule

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-requester round-robin arbiter with held grants and optional hold timeout
//
// Optional feature macro: ARB_TIMEOUT_EN (adds MAX_HOLD parameter and hold counter)
//
// Parameters (only with ARB_TIMEOUT_EN):
//   MAX_HOLD   maximum grant length in cycles, legal range 2..255
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  synchronous active-high reset
//   req      in   4  level-sensitive request vector
//   gnt      out  4  registered one-hot grant, or zero
//   gnt_idx  out  2  registered owner index, 0 when no grant
//   busy     out  1  registered, high while a grant is active
//   timeout  out  1  registered one-cycle pulse after a forced release (0 without ARB_TIMEOUT_EN)

module rr_arbiter_4
   import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
   parameter int MAX_HOLD = 8
)
`endif
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               busy,
   output logic               timeout
);

   logic [0:0]         state_q,   state_d;
   logic [IDX_W-1:0]   ptr_q,     ptr_d;
   logic [NUM_REQ-1:0] gnt_q,     gnt_d;
   logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
   logic               busy_q,    busy_d;
   logic               timeout_q, timeout_d;

   logic [IDX_W-1:0]   win_idx;
   logic               win_valid;
   logic               owner_req;
   logic               force_rel;

   rr_pick_4 u_pick (
      .req       (req),
      .ptr       (ptr_q),
      .win_idx   (win_idx),
      .win_valid (win_valid)
   );

   // While in GRANT, gnt_idx_q is the owner's index.
   assign owner_req = req[gnt_idx_q];

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [7:0] hold_q, hold_d;

   // Counter reads 0 in the first granted cycle, so reaching HOLD_LAST means
   // the grant has been visible for MAX_HOLD cycles.
   assign force_rel = (state_q == ST_GRANT) && owner_req && (hold_q == HOLD_LAST);

   always_comb begin
      hold_d = hold_q;
      if (state_q == ST_IDLE) begin
         hold_d = '0;
      end else if (owner_req && !force_rel) begin
         hold_d = hold_q + 8'd1;
      end else begin
         hold_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end
`else
   assign force_rel = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      gnt_idx_d = gnt_idx_q;
      timeout_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               state_d   = ST_GRANT;
               gnt_d     = idx_to_onehot(win_idx);
               gnt_idx_d = win_idx;
            end else begin
               gnt_d     = '0;
               gnt_idx_d = '0;
            end
         end
         default: begin
            // Voluntary or forced release both demote the owner to lowest
            // priority; non-owner requests are ignored while granted.
            if (!owner_req || force_rel) begin
               state_d   = ST_IDLE;
               ptr_d     = gnt_idx_q + IDX_W'(1);
               gnt_d     = '0;
               gnt_idx_d = '0;
               timeout_d = force_rel;
            end
         end
      endcase

      busy_d = |gnt_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         gnt_q     <= '0;
         gnt_idx_q <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         gnt_idx_q <= gnt_idx_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_idx = gnt_idx_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter that shares one downstream resource among four masters. It grants exactly one requester at a time, holds the grant until that requester releases it, and rotates priority so no requester starves. Besides the one-hot grant it emits the 2-bit encoded owner index, so it can drive a 4:1 mux select directly. It sits between the request lines and the shared datapath's select input.

## Interface
- NUM_REQ, 4, number of requesters; fixed at 4, so the index is 2 bits.
- MAX_HOLD, 8, maximum grant length in cycles when ARB_TIMEOUT_EN is defined; legal range 2..255.
- Ports:
  - clk  input  1  rising-edge clock; the only clock.
  - rst  input  1  reset, synchronous to clk and active-high.
  - req  input  4  request vector; bit i is requester i; level-sensitive.
  - gnt  output  4  one-hot grant, or all zeros; registered.
  - gnt_idx  output  2  encoded index of the current owner; registered; 0 when gnt is all zeros.
  - busy  output  1  high while any grant is active (equals |gnt).
  - timeout  output  1  one-cycle pulse on a forced release; tied 0 when ARB_TIMEOUT_EN is not defined.

## Operation
- State machine has two states:
  - IDLE: no grant is active.
  - GRANT: one owner holds the resource.
- Priority pointer ptr, 2 bits:
  - Search order is ptr, ptr+1, ptr+2, ptr+3, with wrap-around mod 4.
  - The first set req bit in that order wins.
- IDLE transitions:
  - If req is nonzero, load owner = winner, set gnt[owner] and gnt_idx = owner, go to GRANT.
  - If req = 4'b0000, stay in IDLE with outputs at zero.
- GRANT transitions:
  - While req[owner] = 1, hold gnt and gnt_idx unchanged. Other requests are ignored.
  - When req[owner] = 0 at an edge, clear gnt, set gnt_idx = 0, set ptr = owner+1 (mod 4), go to IDLE.
- After every release the owner drops to lowest priority. This gives fairness: a continuously requesting master waits at most 3 other grants.
- Requests that are not currently granted are never latched. A requester that deasserts before winning is simply not served.
- Reset values:
  - State IDLE, ptr = 0, gnt = 0, gnt_idx = 0, busy = 0, timeout = 0, hold counter = 0.
  - After reset, requester 0 has the highest priority.
- Reset mid-grant: the grant drops at the reset edge with no timeout pulse, and ptr returns to 0.

## Timing
- Grant latency:
  - req sampled at edge k sets gnt after edge k.
  - gnt is visible in cycle k+1, one cycle after req is first presented.
- Release latency:
  - The owner deasserting req before edge m clears gnt after edge m.
- Release bubble: there is always exactly one IDLE cycle with gnt = 0 between consecutive grants, including back-to-back handover to another requester.
- Simultaneous requests: if several bits of req rise in the same cycle, only the ptr-order winner is granted. The others wait.
- Owner re-requesting: if the owner deasserts and reasserts immediately, it competes in IDLE at lowest priority.
- gnt, gnt_idx, busy and timeout are all registered outputs; there are no combinational input-to-output paths.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each cycle in GRANT.
  - When the counter reaches MAX_HOLD-1 with req[owner] still high, the next edge forces a release: gnt clears, ptr = owner+1, state goes to IDLE.
  - timeout pulses high for the single cycle after that forced-release edge.
  - The grant therefore lasts at most MAX_HOLD cycles.
- ARB_TIMEOUT_EN not defined:
  - No counter is built, and timeout is constant 0.
  - The grant lasts as long as the owner requests.

## Structure
- Shared package arb_pkg holds:
  - state encoding constants ST_IDLE = 1'b0 and ST_GRANT = 1'b1;
  - NUM_REQ;
  - IDX_W = 2.
- One sub-module, rr_pick_4:
  - Purely combinational.
  - Inputs req[3:0] and ptr[1:0]; outputs win_idx[1:0] and win_valid.
  - Rotates req by ptr, applies a fixed-priority encode, then adds ptr back mod 4.
- The top level holds the FSM, ptr, the output registers and the optional counter.

## Test plan
- Reset priority: assert rst, release it, then drive req = 4'b1111 → after one cycle gnt = 4'b0001, gnt_idx = 0, busy = 1.
- Rotation: keep req = 4'b1111 and drop each owner's bit for one cycle after 3 granted cycles → gnt_idx sequence 0, 1, 2, 3, 0, with one gnt = 0 bubble between each grant.
- Hold and ignore: owner 2 is granted, then req becomes 4'b0111 → gnt stays 4'b0100 until req[2] = 0; next grant is gnt_idx = 0 (ptr = 3, bit 3 clear, wrap to 0).
- Single late requester: with ptr = 1, drive req = 4'b0001 → gnt = 4'b0001 after one cycle; requests that drop while waiting are never granted.
- Mid-grant reset: owner 3 is granted and rst is pulsed → gnt = 0 and timeout = 0 after the reset edge; the next req = 4'b1010 grants index 1.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD = 8): req = 4'b0011 held constant → gnt_idx = 0 for exactly 8 cycles, timeout = 1 for one cycle, one bubble, then gnt_idx = 1 for 8 cycles.
